barrel_shifter_pipe: RTL

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/bshift_pkg.sv | 20 ++
 rtl/bshift_stage.sv | 79 +++++++
 rtl/barrel_shifter_pipe.sv | 78 +++++++
 3 files changed

// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Optional flag support is selected with the BSHIFT_FLAGS_EN macro.
package bshift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Per-stage control record travelling alongside the data word.
  typedef struct packed {
    op_e  op;
`ifdef BSHIFT_FLAGS_EN
    logic carry;
`endif
  } stage_ctrl_t;

endpackage

// File: rtl/bshift_stage.sv
// One barrel-shifter level: conditional shift by 2^BIT, then a register.
// With BSHIFT_FLAGS_EN the last bit shifted out is tracked as carry.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = 4,
  parameter int BIT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              vld,
  input  logic [WIDTH-1:0]  data,
  input  stage_ctrl_t       ctrl,
  input  logic [SW-1:0]     shamt,
  output logic              vld_p,
  output logic [WIDTH-1:0]  data_p,
  output stage_ctrl_t       ctrl_p,
  output logic [SW-1:0]     shamt_p
);

  localparam int DIST = 1 << BIT;

  logic [WIDTH-1:0] nxt_data;
  stage_ctrl_t      nxt_ctrl;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input op_e op);
    logic signed [WIDTH-1:0] sd;
    logic        [WIDTH-1:0] res;
    sd = d;
    case (op)
      OP_SLL:  res = d << DIST;
      OP_SRL:  res = d >> DIST;
      OP_SRA:  res = sd >>> DIST;
      OP_ROR:  res = {d[DIST-1:0], d[WIDTH-1:DIST]};
      default: res = d;
    endcase
    return res;
  endfunction

`ifdef BSHIFT_FLAGS_EN
  // Last bit leaving the word at this level; for ROR this is the new MSB.
  function automatic logic carry_bit(input logic [WIDTH-1:0] d, input op_e op);
    logic c;
    if (op == OP_SLL) c = d[WIDTH-DIST];
    else              c = d[DIST-1];
    return c;
  endfunction
`endif

  // Mux level: apply this stage's distance when its shamt bit is set.
  always_comb begin
    nxt_ctrl = ctrl;
    nxt_data = data;
    if (shamt[BIT]) begin
      nxt_data = shift_step(data, ctrl.op);
`ifdef BSHIFT_FLAGS_EN
      nxt_ctrl.carry = carry_bit(data, ctrl.op);
`endif
    end
  end

  // Stage boundary: valid is reset, everything advances only when enabled.
  always_ff @(posedge clk) begin
    if (reset)   vld_p <= 1'b0;
    else if (en) vld_p <= vld;
  end

  // Stage boundary: data path register, no reset needed.
  always_ff @(posedge clk) begin
    if (en) begin
      data_p  <= nxt_data;
      ctrl_p  <= nxt_ctrl;
      shamt_p <= shamt;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), log2(WIDTH) stages,
// valid/ready handshake with whole-pipe stall on back-pressure.
// Define BSHIFT_FLAGS_EN to add out_zero / out_carry.
module barrel_shifter_pipe
  import bshift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  // Index 0 is the input beat; index k+1 is the register of stage k.
  logic             stg_vld   [SW+1];
  logic [WIDTH-1:0] stg_data  [SW+1];
  stage_ctrl_t      stg_ctrl  [SW+1];
  logic [SW-1:0]    stg_shamt [SW+1];
  stage_ctrl_t      ctrl_p0;

  // Build the control record for the incoming beat.
  always_comb begin
    ctrl_p0    = '0;
    ctrl_p0.op = op_e'(in_op);
  end

  assign stg_vld[0]   = in_valid;
  assign stg_data[0]  = in_data;
  assign stg_ctrl[0]  = ctrl_p0;
  assign stg_shamt[0] = in_shamt;

  // Whole pipe advances together; bubbles advance like beats.
  assign out_valid = stg_vld[SW];
  assign in_ready  = !out_valid || out_ready;

  // Largest distance first: stage k handles shamt bit SW-1-k.
  for (genvar k = 0; k < SW; k++) begin : g_stage
    bshift_stage #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .BIT   (SW - 1 - k)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (in_ready),
      .vld     (stg_vld[k]),
      .data    (stg_data[k]),
      .ctrl    (stg_ctrl[k]),
      .shamt   (stg_shamt[k]),
      .vld_p   (stg_vld[k+1]),
      .data_p  (stg_data[k+1]),
      .ctrl_p  (stg_ctrl[k+1]),
      .shamt_p (stg_shamt[k+1])
    );
  end

  // Outputs read zero whenever no result is present (including after reset).
  assign out_data = out_valid ? stg_data[SW] : '0;

`ifdef BSHIFT_FLAGS_EN
  assign out_zero  = out_valid && (stg_data[SW] == '0);
  assign out_carry = out_valid && stg_ctrl[SW].carry;
`endif

endmodule
